debounced_accumulator: RTL and testbench

//  Parametrised push-button accumulator. Each debounced press adds or subtracts OPERAND into a

---
 rtl/debounced_accumulator.sv | 183 ++++++++++++++++++
 tb/tb_debounced_accumulator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_accumulator.sv
// debounced_accumulator
//   Push-button accumulator: a raw, bouncy button is synchronised and debounced.
//   Each accepted press adds or subtracts `operand` into a WIDTH-bit register.
//   The register has true carry/borrow, a sticky overflow flag and a press counter.
//   Optional build macro: SATURATE_EN. When defined, a result that carries or borrows
//   clamps to all-ones (add) or zero (sub) instead of wrapping.
module debounced_accumulator #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] operand,
  input  logic             sub,
  input  logic             clr_n,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             ovf_sticky,
  output logic             press_pulse,
  output logic [CNT_W-1:0] press_cnt,
  output logic             db_level
);

  localparam int DBC_W = $clog2(DB_CYCLES) + 1;
  localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } db_state_t;

  // (WIDTH+1)-bit add/subtract; the top bit is carry-out on add and borrow on subtract
  function automatic logic [WIDTH:0] acc_op(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             do_sub);
    logic [WIDTH:0] res;
    if (do_sub) begin
      res = {1'b0, a} - {1'b0, b};
    end else begin
      res = {1'b0, a} + {1'b0, b};
    end
    return res;
  endfunction

  logic [1:0]       sync_r;
  logic             btn_s;
  db_state_t        state_r;
  db_state_t        state_nxt_s;
  logic [DBC_W-1:0] db_cnt_r;
  logic [DBC_W-1:0] db_cnt_nxt_s;
  logic             pulse_nxt_s;
  logic [WIDTH:0]   op_res_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic             carry_nxt_s;

  assign btn_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

  // Debounce next-state logic.
  // The IDLE->ARMING sample is not counted, so DB_CYCLES further 1-samples are needed to accept a press.
  always_comb begin
    state_nxt_s  = state_r;
    db_cnt_nxt_s = db_cnt_r;
    pulse_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        db_cnt_nxt_s = '0;
        if (btn_s) begin
          state_nxt_s = ARMING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMING: begin
        if (!btn_s) begin
          state_nxt_s  = IDLE;
          db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DB_LAST) begin
          state_nxt_s  = HELD;
          db_cnt_nxt_s = '0;
          pulse_nxt_s  = 1'b1;
        end else begin
          db_cnt_nxt_s = db_cnt_r + DBC_W'(1);
        end
      end
      HELD: begin
        db_cnt_nxt_s = '0;
        if (!btn_s) begin
          state_nxt_s = RELEASING;
        end else begin
          state_nxt_s = HELD;
        end
      end
      RELEASING: begin
        if (btn_s) begin
          state_nxt_s  = HELD;
          db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DB_LAST) begin
          state_nxt_s  = IDLE;
          db_cnt_nxt_s = '0;
        end else begin
          db_cnt_nxt_s = db_cnt_r + DBC_W'(1);
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        db_cnt_nxt_s = '0;
      end
    endcase
  end

  // Debounce state, counter, registered press strobe and debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      db_cnt_r    <= '0;
      press_pulse <= 1'b0;
      db_level    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      db_cnt_r    <= db_cnt_nxt_s;
      press_pulse <= pulse_nxt_s;
      db_level    <= (state_nxt_s == HELD) || (state_nxt_s == RELEASING);
    end
  end

  // Arithmetic result for the next accumulate edge, with optional clamping
  always_comb begin
    op_res_s    = acc_op(acc, operand, sub);
    carry_nxt_s = op_res_s[WIDTH];
    acc_nxt_s   = op_res_s[WIDTH-1:0];
`ifdef SATURATE_EN
    if (carry_nxt_s) begin
      if (sub) begin
        acc_nxt_s = '0;
      end else begin
        acc_nxt_s = {WIDTH{1'b1}};
      end
    end else begin
      acc_nxt_s = op_res_s[WIDTH-1:0];
    end
`endif
  end

  // Accumulator, flags and press counter.
  // Clear takes priority and discards a coincident press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
      press_cnt  <= '0;
    end else if (!clr_n) begin
      acc        <= '0;
      carry      <= 1'b0;
      ovf_sticky <= 1'b0;
      press_cnt  <= '0;
    end else if (press_pulse) begin
      acc        <= acc_nxt_s;
      carry      <= carry_nxt_s;
      ovf_sticky <= ovf_sticky | carry_nxt_s;
      press_cnt  <= press_cnt + CNT_W'(1);
    end else begin
      acc        <= acc;
      carry      <= carry;
      ovf_sticky <= ovf_sticky;
      press_cnt  <= press_cnt;
    end
  end

endmodule

// File: tb/tb_debounced_accumulator.sv
// Directed testbench for debounced_accumulator (WIDTH=8, DB_CYCLES=4, CNT_W=8).
// Expected values are hand-computed and follow the SATURATE_EN build macro where relevant.
module tb_debounced_accumulator;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic [7:0] operand;
  logic       sub;
  logic       clr_n;
  logic [7:0] acc;
  logic       carry;
  logic       ovf_sticky;
  logic       press_pulse;
  logic [7:0] press_cnt;
  logic       db_level;

  int checks   = 0;
  int failures = 0;
  int lat;
  int npulse;

  debounced_accumulator #(.WIDTH(8), .DB_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .operand     (operand),
    .sub         (sub),
    .clr_n       (clr_n),
    .acc         (acc),
    .carry       (carry),
    .ovf_sticky  (ovf_sticky),
    .press_pulse (press_pulse),
    .press_cnt   (press_cnt),
    .db_level    (db_level)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, leaving the bench 1 ns after the last edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until press_pulse is seen; return the edge count, or -1 on timeout
  task automatic wait_pulse(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (press_pulse) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Press, let the accumulate land, then release fully back to IDLE
  task automatic press(input logic [7:0] op, input logic sb, input string tag);
    int c;
    operand = op;
    sub     = sb;
    btn_raw = 1'b1;
    wait_pulse(c);
    check({tag, "_latency"}, c, 7);
    step(1);
    btn_raw = 1'b0;
    step(10);
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    operand = 8'd0;
    sub     = 1'b0;
    clr_n   = 1'b1;
    step(3);
    check("rst_acc", acc, 0);
    check("rst_flags", {carry, ovf_sticky, press_pulse, db_level}, 0);
    check("rst_cnt", press_cnt, 0);
    rst_n = 1'b1;
    step(2);

    // 1: clean press of +5, 7-cycle latency, single pulse while held
    operand = 8'd5;
    sub     = 1'b0;
    btn_raw = 1'b1;
    wait_pulse(lat);
    check("t1_latency", lat, 7);
    check("t1_acc_before", acc, 0);
    step(1);
    check("t1_pulse_width", press_pulse, 0);
    check("t1_acc", acc, 5);
    check("t1_carry", carry, 0);
    check("t1_cnt", press_cnt, 1);
    check("t1_level", db_level, 1);
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (press_pulse) npulse++;
    end
    check("t1_hold_pulses", npulse, 0);
    check("t1_hold_acc", acc, 5);
    btn_raw = 1'b0;
    step(10);
    check("t1_release_level", db_level, 0);

    // 2: 3-cycle glitches must not be accepted
    npulse = 0;
    for (int g = 0; g < 6; g++) begin
      btn_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step(1);
        if (press_pulse) npulse++;
      end
      btn_raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
        step(1);
        if (press_pulse) npulse++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (press_pulse) npulse++;
    end
    check("t2_glitch_pulses", npulse, 0);
    check("t2_acc", acc, 5);
    check("t2_cnt", press_cnt, 1);

    // 3: 5+245 = 250 without carry, then 250+10 overflows
    press(8'd245, 1'b0, "t3a");
    check("t3a_acc", acc, 250);
    check("t3a_flags", {carry, ovf_sticky}, 2'b00);
    press(8'd10, 1'b0, "t3b");
`ifdef SATURATE_EN
    check("t3b_acc", acc, 255);
`else
    check("t3b_acc", acc, 4);
`endif
    check("t3b_flags", {carry, ovf_sticky}, 2'b11);
    check("t3b_cnt", press_cnt, 3);

    // 4: clear, 0+3 = 3, then 3-5 borrows, then a borrow-free op
    clr_n = 1'b0;
    step(1);
    clr_n = 1'b1;
    check("t4_clr_acc", acc, 0);
    check("t4_clr_flags", {carry, ovf_sticky}, 2'b00);
    check("t4_clr_cnt", press_cnt, 0);
    press(8'd3, 1'b0, "t4a");
    check("t4a_acc", acc, 3);
    press(8'd5, 1'b1, "t4b");
`ifdef SATURATE_EN
    check("t4b_acc", acc, 0);
`else
    check("t4b_acc", acc, 254);
`endif
    check("t4b_flags", {carry, ovf_sticky}, 2'b11);
    press(8'd1, 1'b0, "t4c");
`ifdef SATURATE_EN
    check("t4c_acc", acc, 1);
`else
    check("t4c_acc", acc, 255);
`endif
    check("t4c_flags", {carry, ovf_sticky}, 2'b01);
    check("t4c_cnt", press_cnt, 3);

    // 5: clear coincident with press_pulse discards that press
    operand = 8'd9;
    sub     = 1'b0;
    btn_raw = 1'b1;
    wait_pulse(lat);
    check("t5_latency", lat, 7);
    clr_n = 1'b0;
    step(1);
    clr_n = 1'b1;
    check("t5_acc", acc, 0);
    check("t5_cnt", press_cnt, 0);
    check("t5_flags", {carry, ovf_sticky}, 2'b00);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (press_pulse) npulse++;
    end
    check("t5_no_refire", npulse, 0);
    check("t5_acc_held", acc, 0);
    btn_raw = 1'b0;
    step(10);

    // 6: async reset while ARMING, button held through reset release
    press(8'd7, 1'b0, "t6pre");
    check("t6pre_acc", acc, 7);
    btn_raw = 1'b1;
    step(4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_acc", acc, 0);
    check("t6_async_cnt", press_cnt, 0);
    check("t6_async_flags", {carry, ovf_sticky, press_pulse, db_level}, 0);
    step(2);
    rst_n = 1'b1;
    wait_pulse(lat);
    check("t6_latency", lat, 7);
    step(1);
    check("t6_acc", acc, 7);
    check("t6_cnt", press_cnt, 1);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (press_pulse) npulse++;
    end
    check("t6_single", npulse, 0);
    btn_raw = 1'b0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
